// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered, handshaked ALU. Logic/arithmetic ops finish in
// one cycle; SLL/SRL/SRA walk one bit per cycle through an accumulator.
// Result and Zero are held in DONE until the consumer takes them.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [3:0]       ALUCtrl,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             IllegalOp
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LEFT, SH_RIGHT_LOG, SH_RIGHT_ARITH} shift_kind_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   state_t           state_q, state_d;
   shift_kind_t      kind_q, new_kind;
   logic [WIDTH-1:0] acc_q, acc_next;
   logic [SHW-1:0]   cnt_q;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_illegal;
   logic             is_shift;
   logic             slt_bit;
   logic             accept;
   logic             go_shift;

   assign shamt    = OpB[SHW-1:0];
   assign slt_bit  = $signed(OpA) < $signed(OpB);
   assign InReady  = (state_q == IDLE) || ((state_q == DONE) && OutReady);
   assign accept   = InValid && InReady;
   assign go_shift = is_shift && (shamt != '0);
   assign OutValid = (state_q == DONE);

   // Decode the op code into a single-cycle result or a shift request.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case leaves it unassigned and infers a latch.
      alu_res     = '0;
      alu_illegal = 1'b0;
      is_shift    = 1'b0;
      new_kind    = SH_LEFT;
      case (ALUCtrl)
         OP_AND: alu_res = OpA & OpB;
         OP_OR:  alu_res = OpA | OpB;
         OP_ADD: alu_res = OpA + OpB;
         OP_SUB: alu_res = OpA - OpB;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_NOR: alu_res = ~(OpA | OpB);
         OP_SLL: begin is_shift = 1'b1; new_kind = SH_LEFT;        alu_res = OpA; end
         OP_SRL: begin is_shift = 1'b1; new_kind = SH_RIGHT_LOG;   alu_res = OpA; end
         OP_SRA: begin is_shift = 1'b1; new_kind = SH_RIGHT_ARITH; alu_res = OpA; end
         default: alu_illegal = 1'b1;
      endcase
   end

   // One-bit step of the accumulator in the direction captured at accept.
   always_comb begin
      acc_next = acc_q;
      case (kind_q)
         SH_LEFT:        acc_next = {acc_q[WIDTH-2:0], 1'b0};
         SH_RIGHT_LOG:   acc_next = {1'b0, acc_q[WIDTH-1:1]};
         SH_RIGHT_ARITH: acc_next = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
         default:        acc_next = acc_q;
      endcase
   end

   // Next state: accept from IDLE/DONE, count down in SHIFT, drain DONE to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept)                           state_d = go_shift ? SHIFT : DONE;
            else if ((state_q == DONE) && OutReady) state_d = IDLE;
         end
         SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      // NOTE: clocked state uses non-blocking assignment so every register sees
      // the pre-edge values of its neighbours, independent of statement order.
      else        state_q <= state_d;
   end

   // Datapath: load results on accept, step the shifter, publish on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the accumulator and counter are reset as well, so a shift cut
         // off by reset cannot leak any partial value into a later operation.
         acc_q     <= '0;
         cnt_q     <= '0;
         kind_q    <= SH_LEFT;
         Result    <= '0;
         Zero      <= 1'b0;
         IllegalOp <= 1'b0;
      end else if (accept) begin
         if (go_shift) begin
            acc_q  <= OpA;
            cnt_q  <= shamt;
            kind_q <= new_kind;
         end else begin
            Result    <= alu_res;
            Zero      <= (alu_res == '0);
            IllegalOp <= alu_illegal;
         end
      end else if (state_q == SHIFT) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            Result    <= acc_next;
            Zero      <= (acc_next == '0);
            IllegalOp <= 1'b0;
         end
      end
   end

endmodule
